// File: rtl/aib_rstseq_pkg.sv
// Shared types and default parameters for the AIB adapter reset-release sequencer.
package aib_rstseq_pkg;

    localparam int unsigned NUM_STAGES_DEF = 4;
    localparam int unsigned CNT_WIDTH_DEF  = 8;
    localparam int unsigned ACK_TMO_DEF    = 255;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } seq_state_t;

endpackage

// File: rtl/aib_rstseq_dncnt.sv
// Loadable saturating down-counter; load wins over dec, zero_c flags an empty count.
module aib_rstseq_dncnt
    import aib_rstseq_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 zero_c
);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/aib_rstseq_ctrl.sv
// Releases the downstream domain resets one at a time, waiting for each domain's ack,
// with a programmable inter-stage delay and a per-stage ack timeout.
module aib_rstseq_ctrl
    import aib_rstseq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int unsigned ACK_TMO    = ACK_TMO_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold_sync,
    input  logic [CNT_WIDTH-1:0]  cfg_dly,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  seq_done,
    output logic                  seq_err,
    output logic [2:0]            seq_state
);

    localparam int unsigned          IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LOAD = CNT_WIDTH'(ACK_TMO);
    localparam bit                   TMO_EN   = (ACK_TMO != 0);

    seq_state_t       state;
    logic [IDX_W-1:0] idx;

    logic ack_cur_c;
    logic all_ack_c;
    logic dly_load_c;
    logic dly_dec_c;
    logic dly_zero_c;
    logic tmo_load_c;
    logic tmo_dec_c;
    logic tmo_zero_c;

    assign ack_cur_c = stage_ack[idx];
    assign all_ack_c = &stage_ack;
    assign seq_state = state;

    // Counter controls; hold_sync suppresses all counter activity.
    always_comb begin
        dly_load_c = 1'b0;
        dly_dec_c  = 1'b0;
        tmo_load_c = 1'b0;
        tmo_dec_c  = 1'b0;
        if (!hold_sync) begin
            case (state)
                ST_HOLD: dly_load_c = 1'b1;
                ST_DELAY: begin
                    if (dly_zero_c) tmo_load_c = 1'b1;
                    else            dly_dec_c  = 1'b1;
                end
                ST_WAIT_ACK: begin
                    if (ack_cur_c) begin
                        if (idx != LAST_IDX) dly_load_c = 1'b1;
                    end else if (TMO_EN && !tmo_zero_c) begin
                        tmo_dec_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    aib_rstseq_dncnt #(.CNT_WIDTH(CNT_WIDTH)) u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (dly_load_c),
        .load_val (cfg_dly),
        .dec      (dly_dec_c),
        .zero_c   (dly_zero_c)
    );

    aib_rstseq_dncnt #(.CNT_WIDTH(CNT_WIDTH)) u_tmo_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (tmo_load_c),
        .load_val (TMO_LOAD),
        .dec      (tmo_dec_c),
        .zero_c   (tmo_zero_c)
    );

    // Sequencer FSM with registered outputs; hold_sync overrides every state.
    always_ff @(posedge clk) begin
        if (rst || hold_sync) begin
            state     <= ST_HOLD;
            idx       <= '0;
            stage_rst <= '1;
            seq_done  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: state <= ST_DELAY;
                ST_DELAY: begin
                    if (dly_zero_c) begin
                        stage_rst[idx] <= 1'b0;
                        state          <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_cur_c) begin
                        if (idx == LAST_IDX) begin
                            state    <= ST_DONE;
                            seq_done <= 1'b1;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_DELAY;
                        end
                    end else if (TMO_EN && tmo_zero_c) begin
                        state     <= ST_ERR;
                        seq_err   <= 1'b1;
                        seq_done  <= 1'b0;
                        stage_rst <= '1;
                    end
                end
                ST_DONE: begin
                    if (!all_ack_c) begin
                        state     <= ST_ERR;
                        seq_err   <= 1'b1;
                        seq_done  <= 1'b0;
                        stage_rst <= '1;
                    end
                end
                ST_ERR: begin
                    seq_err   <= 1'b1;
                    seq_done  <= 1'b0;
                    stage_rst <= '1;
                end
                default: begin
                    state     <= ST_ERR;
                    seq_err   <= 1'b1;
                    seq_done  <= 1'b0;
                    stage_rst <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aib_rstseq_ctrl.sv
// Directed testbench for aib_rstseq_ctrl: 4 stages, 8-bit counters, ack timeout of 5.
module tb_aib_rstseq_ctrl;

    localparam int unsigned NS  = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned TMO = 5;

    localparam logic [2:0] S_HOLD = 3'd0;
    localparam logic [2:0] S_DLY  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic          clk;
    logic          rst;
    logic          hold_sync;
    logic [CW-1:0] cfg_dly;
    logic [NS-1:0] stage_ack;
    logic [NS-1:0] stage_rst;
    logic          seq_done;
    logic          seq_err;
    logic [2:0]    seq_state;

    int checks = 0;
    int errors = 0;

    logic [NS-1:0] ones = 4'hF;
    logic [NS-1:0] exp_before;
    logic [NS-1:0] exp_after;

    aib_rstseq_ctrl #(.NUM_STAGES(NS), .CNT_WIDTH(CW), .ACK_TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold_sync (hold_sync),
        .cfg_dly   (cfg_dly),
        .stage_ack (stage_ack),
        .stage_rst (stage_rst),
        .seq_done  (seq_done),
        .seq_err   (seq_err),
        .seq_state (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are observed on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic enter_hold(input logic [CW-1:0] dly);
        hold_sync = 1'b1;
        stage_ack = '0;
        cfg_dly   = dly;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; hold_sync = 1'b0; cfg_dly = '0; stage_ack = '0;
        tick(); tick();
        checks++;
        if ({stage_rst, seq_done, seq_err, seq_state} !== {4'hF, 1'b0, 1'b0, S_HOLD}) begin
            errors++;
            $display("FAIL reset_values got rst=%b done=%b err=%b st=%0d exp rst=1111 done=0 err=0 st=0",
                     stage_rst, seq_done, seq_err, seq_state);
        end
        rst = 1'b0; hold_sync = 1'b1;
        tick();
        checks++;
        if ({stage_rst, seq_state} !== {4'hF, S_HOLD}) begin
            errors++;
            $display("FAIL hold_after_reset got rst=%b st=%0d exp rst=1111 st=0", stage_rst, seq_state);
        end
    endtask

    task automatic test_nominal();
        enter_hold(8'd3);
        hold_sync = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_before = ones << k;
            exp_after  = ones << (k + 1);
            for (int i = 0; i < 4; i++) begin
                tick();
                if (k == 0 && i == 0) cfg_dly = 8'd0;
            end
            checks++;
            if ({stage_rst, seq_state} !== {exp_before, S_DLY}) begin
                errors++;
                $display("FAIL nominal_pre%0d got rst=%b st=%0d exp rst=%b st=1", k, stage_rst, seq_state, exp_before);
            end
            tick();
            checks++;
            if ({stage_rst, seq_state} !== {exp_after, S_WAIT}) begin
                errors++;
                $display("FAIL nominal_rel%0d got rst=%b st=%0d exp rst=%b st=2", k, stage_rst, seq_state, exp_after);
            end
            cfg_dly = 8'd3;
            tick(); tick();
            stage_ack[k] = 1'b1;
        end
        checks++;
        if (seq_done !== 1'b0) begin
            errors++;
            $display("FAIL nominal_done_early got %b exp 0", seq_done);
        end
        tick();
        checks++;
        if ({stage_rst, seq_done, seq_err, seq_state} !== {4'h0, 1'b1, 1'b0, S_DONE}) begin
            errors++;
            $display("FAIL nominal_done got rst=%b done=%b err=%b st=%0d exp rst=0000 done=1 err=0 st=3",
                     stage_rst, seq_done, seq_err, seq_state);
        end
    endtask

    task automatic test_zero_delay();
        enter_hold(8'd0);
        hold_sync = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_before = ones << k;
            exp_after  = ones << (k + 1);
            tick();
            checks++;
            if ({stage_rst, seq_state} !== {exp_before, S_DLY}) begin
                errors++;
                $display("FAIL zero_pre%0d got rst=%b st=%0d exp rst=%b st=1", k, stage_rst, seq_state, exp_before);
            end
            tick();
            checks++;
            if ({stage_rst, seq_state} !== {exp_after, S_WAIT}) begin
                errors++;
                $display("FAIL zero_rel%0d got rst=%b st=%0d exp rst=%b st=2", k, stage_rst, seq_state, exp_after);
            end
            stage_ack[k] = 1'b1;
        end
        tick();
        checks++;
        if ({seq_done, seq_state} !== {1'b1, S_DONE}) begin
            errors++;
            $display("FAIL zero_done got done=%b st=%0d exp done=1 st=3", seq_done, seq_state);
        end
    endtask

    task automatic test_timeout();
        enter_hold(8'd0);
        hold_sync = 1'b0;
        tick(); tick();
        stage_ack[0] = 1'b1;
        tick(); tick();
        checks++;
        if ({stage_rst, seq_state} !== {4'b1100, S_WAIT}) begin
            errors++;
            $display("FAIL tmo_rel1 got rst=%b st=%0d exp rst=1100 st=2", stage_rst, seq_state);
        end
        repeat (5) tick();
        checks++;
        if ({seq_err, seq_state} !== {1'b0, S_WAIT}) begin
            errors++;
            $display("FAIL tmo_early got err=%b st=%0d exp err=0 st=2", seq_err, seq_state);
        end
        tick();
        checks++;
        if ({stage_rst, seq_done, seq_err, seq_state} !== {4'hF, 1'b0, 1'b1, S_ERR}) begin
            errors++;
            $display("FAIL tmo_err got rst=%b done=%b err=%b st=%0d exp rst=1111 done=0 err=1 st=4",
                     stage_rst, seq_done, seq_err, seq_state);
        end
        stage_ack = 4'hF;
        tick(); tick();
        checks++;
        if ({stage_rst, seq_err, seq_state} !== {4'hF, 1'b1, S_ERR}) begin
            errors++;
            $display("FAIL tmo_sticky got rst=%b err=%b st=%0d exp rst=1111 err=1 st=4", stage_rst, seq_err, seq_state);
        end
        hold_sync = 1'b1;
        tick();
        checks++;
        if ({stage_rst, seq_done, seq_err, seq_state} !== {4'hF, 1'b0, 1'b0, S_HOLD}) begin
            errors++;
            $display("FAIL tmo_clear got rst=%b done=%b err=%b st=%0d exp rst=1111 done=0 err=0 st=0",
                     stage_rst, seq_done, seq_err, seq_state);
        end
    endtask

    task automatic test_ack_tmo_coincide();
        enter_hold(8'd0);
        hold_sync = 1'b0;
        tick(); tick();
        stage_ack[0] = 1'b1;
        tick(); tick();
        repeat (5) tick();
        stage_ack[1] = 1'b1;
        tick();
        checks++;
        if ({stage_rst, seq_err, seq_state} !== {4'b1100, 1'b0, S_DLY}) begin
            errors++;
            $display("FAIL coincide_adv got rst=%b err=%b st=%0d exp rst=1100 err=0 st=1", stage_rst, seq_err, seq_state);
        end
        tick();
        checks++;
        if ({stage_rst, seq_err, seq_state} !== {4'b1000, 1'b0, S_WAIT}) begin
            errors++;
            $display("FAIL coincide_rel2 got rst=%b err=%b st=%0d exp rst=1000 err=0 st=2", stage_rst, seq_err, seq_state);
        end
    endtask

    task automatic test_mid_hold();
        enter_hold(8'd3);
        hold_sync = 1'b0;
        repeat (5) tick();
        stage_ack[0] = 1'b1;
        repeat (5) tick();
        stage_ack[1] = 1'b1;
        tick(); tick();
        checks++;
        if ({stage_rst, seq_state} !== {4'b1100, S_DLY}) begin
            errors++;
            $display("FAIL midhold_pre got rst=%b st=%0d exp rst=1100 st=1", stage_rst, seq_state);
        end
        hold_sync = 1'b1;
        tick();
        checks++;
        if ({stage_rst, seq_done, seq_err, seq_state} !== {4'hF, 1'b0, 1'b0, S_HOLD}) begin
            errors++;
            $display("FAIL midhold got rst=%b done=%b err=%b st=%0d exp rst=1111 done=0 err=0 st=0",
                     stage_rst, seq_done, seq_err, seq_state);
        end
        // A fresh release must restart from stage 0.
        stage_ack = '0; cfg_dly = 8'd0; hold_sync = 1'b0;
        tick(); tick();
        checks++;
        if (stage_rst !== 4'b1110) begin
            errors++;
            $display("FAIL midhold_idx got rst=%b exp rst=1110", stage_rst);
        end
        enter_hold(8'd0);
        hold_sync = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); tick();
            stage_ack[k] = 1'b1;
        end
        tick(); tick();
        checks++;
        if ({stage_rst, seq_state} !== {4'h0, S_WAIT}) begin
            errors++;
            $display("FAIL hold_last_pre got rst=%b st=%0d exp rst=0000 st=2", stage_rst, seq_state);
        end
        stage_ack[3] = 1'b1;
        hold_sync    = 1'b1;
        tick();
        checks++;
        if ({stage_rst, seq_done, seq_err, seq_state} !== {4'hF, 1'b0, 1'b0, S_HOLD}) begin
            errors++;
            $display("FAIL hold_last got rst=%b done=%b err=%b st=%0d exp rst=1111 done=0 err=0 st=0",
                     stage_rst, seq_done, seq_err, seq_state);
        end
    endtask

    task automatic test_ack_loss_reset();
        enter_hold(8'd0);
        hold_sync = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(); tick();
            stage_ack[k] = 1'b1;
        end
        tick();
        checks++;
        if ({seq_done, seq_state} !== {1'b1, S_DONE}) begin
            errors++;
            $display("FAIL loss_pre got done=%b st=%0d exp done=1 st=3", seq_done, seq_state);
        end
        stage_ack[3] = 1'b0;
        tick();
        checks++;
        if ({stage_rst, seq_done, seq_err, seq_state} !== {4'hF, 1'b0, 1'b1, S_ERR}) begin
            errors++;
            $display("FAIL ack_loss got rst=%b done=%b err=%b st=%0d exp rst=1111 done=0 err=1 st=4",
                     stage_rst, seq_done, seq_err, seq_state);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({stage_rst, seq_done, seq_err, seq_state} !== {4'hF, 1'b0, 1'b0, S_HOLD}) begin
            errors++;
            $display("FAIL rst_from_err got rst=%b done=%b err=%b st=%0d exp rst=1111 done=0 err=0 st=0",
                     stage_rst, seq_done, seq_err, seq_state);
        end
        stage_ack = '0;
        rst = 1'b0;
        tick();
        checks++;
        if (seq_state !== S_DLY) begin
            errors++;
            $display("FAIL rst_release got st=%0d exp st=1", seq_state);
        end
        tick();
        stage_ack[0] = 1'b1;
        tick(); tick();
        checks++;
        if (stage_rst !== 4'b1100) begin
            errors++;
            $display("FAIL rst_mid_pre got rst=%b exp rst=1100", stage_rst);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({stage_rst, seq_done, seq_err, seq_state} !== {4'hF, 1'b0, 1'b0, S_HOLD}) begin
            errors++;
            $display("FAIL rst_mid got rst=%b done=%b err=%b st=%0d exp rst=1111 done=0 err=0 st=0",
                     stage_rst, seq_done, seq_err, seq_state);
        end
        rst = 1'b0; hold_sync = 1'b1; stage_ack = '0;
        tick();
    endtask

    initial begin
        tick();
        test_reset();
        test_nominal();
        test_zero_delay();
        test_timeout();
        test_ack_tmo_coincide();
        test_mid_hold();
        test_ack_loss_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1, "watchdog");
    end

endmodule
